// File: rtl/memgame_pkg.sv
// memgame_pkg: shared types and constants for the memory-game round sequencer.
//   state_e      - round FSM states
//   SYM_W/PAT_W  - symbol width and pattern register width
//   LFSR_TAPS    - Galois feedback mask for taps 64,63,61,60 (right-shifting form)
//   lfsr_advance - one Galois step of the pattern LFSR
//   max_u        - constant helper for sizing counters
package memgame_pkg;

  localparam int unsigned SYM_W = 4;
  localparam int unsigned PAT_W = 64;

  localparam logic [PAT_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHOW  = 3'd2,
    ST_GAP   = 3'd3,
    ST_INPUT = 3'd4,
    ST_CHECK = 3'd5,
    ST_WIN   = 3'd6,
    ST_LOSE  = 3'd7
  } state_e;

  function automatic logic [PAT_W-1:0] lfsr_advance(input logic [PAT_W-1:0] v);
    return {1'b0, v[PAT_W-1:1]} ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/memgame_lfsr64.sv
// memgame_lfsr64: 64-bit Galois LFSR that advances only when asked.
//   clk  in   system clock
//   rst  in   synchronous active-high reset, reloads SEED
//   step in   advance one Galois step this cycle
//   q    out  current LFSR state
module memgame_lfsr64
  import memgame_pkg::*;
#(
  parameter logic [PAT_W-1:0] SEED = 64'hACE1_0000_0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [PAT_W-1:0] q
);

  logic [PAT_W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SEED;
    end else if (step) begin
      q_q <= lfsr_advance(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/memgame_round_ctrl.sv
// memgame_round_ctrl: memory-game round sequencer. Loads a fresh LFSR pattern
// into the dual register, shows the first `level` nibbles (highest first),
// collects the same number of button presses, compares and advances/ends.
//   clk, rst             clock, synchronous active-high reset
//   start                begin a game from IDLE/WIN/LOSE
//   btn_valid, btn_code  debounced press and its symbol
//   reg_x, reg_y         dual register contents (pattern, entries)
//   reg_en, reg_a, reg_b dual register write port
//   disp_valid, disp_code symbol to display
//   level, busy, win, lose game status
// Optional build macro MEMGAME_TIMEOUT_EN: lose after TIMEOUT_CYCLES without
// a press while waiting for input.
module memgame_round_ctrl
  import memgame_pkg::*;
#(
  parameter int unsigned      SHOW_CYCLES    = 50000000,
  parameter int unsigned      GAP_CYCLES     = 12500000,
  parameter int unsigned      MAX_LEVEL      = 16,
  parameter logic [PAT_W-1:0] SEED           = 64'hACE1_0000_0000_0001,
  parameter int unsigned      TIMEOUT_CYCLES = 500000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             btn_valid,
  input  logic [SYM_W-1:0] btn_code,
  input  logic [PAT_W-1:0] reg_x,
  input  logic [PAT_W-1:0] reg_y,
  output logic             reg_en,
  output logic [PAT_W-1:0] reg_a,
  output logic [PAT_W-1:0] reg_b,
  output logic             disp_valid,
  output logic [SYM_W-1:0] disp_code,
  output logic [4:0]       level,
  output logic             busy,
  output logic             win,
  output logic             lose
);

  // One shared interval counter, sized for the longest interval including the input timeout.
  localparam int unsigned CNT_MAX = max_u(max_u(SHOW_CYCLES, GAP_CYCLES), TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [4:0]       level_q, level_d;
  logic [3:0]       idx_q, idx_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             wr_q;
  logic             wr;
  logic             press;
  logic [PAT_W-1:0] lfsr_q, lfsr_nx, lvl_mask;

  memgame_lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (state_q == ST_LOAD),
    .q    (lfsr_q)
  );

  assign lfsr_nx  = lfsr_advance(lfsr_q);
  assign lvl_mask = (level_q >= 5'd16) ? '1 : ((64'd1 << {level_q, 2'b00}) - 64'd1);
  // A press right after a register write is dropped so writes never land back to back.
  assign press    = btn_valid && !wr_q;

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    wr         = 1'b0;
    reg_a      = '0;
    reg_b      = '0;
    disp_valid = 1'b0;
    disp_code  = '0;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          level_d = 5'd1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wr      = 1'b1;
        reg_a   = lfsr_nx;
        idx_d   = 4'(level_q - 5'd1);
        tcnt_d  = '0;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        disp_valid = 1'b1;
        disp_code  = reg_x[{idx_q, 2'b00} +: SYM_W];
        if (tcnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
          tcnt_d  = '0;
          state_d = ST_GAP;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (tcnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          tcnt_d = '0;
          if (idx_q == 4'd0) begin
            cnt_d   = '0;
            state_d = ST_INPUT;
          end else begin
            idx_d   = idx_q - 4'd1;
            state_d = ST_SHOW;
          end
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      ST_INPUT: begin
        if (press) begin
          wr     = 1'b1;
          reg_a  = reg_x;
          reg_b  = {reg_y[PAT_W-SYM_W-1:0], btn_code};
          cnt_d  = cnt_q + 5'd1;
          tcnt_d = '0;
          if (cnt_q + 5'd1 == level_q) state_d = ST_CHECK;
        end
`ifdef MEMGAME_TIMEOUT_EN
        else if (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_LOSE;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
`endif
      end
      ST_CHECK: begin
        if (((reg_x ^ reg_y) & lvl_mask) != '0) begin
          state_d = ST_LOSE;
        end else if (level_q == 5'(MAX_LEVEL)) begin
          state_d = ST_WIN;
        end else begin
          level_d = level_q + 5'd1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The register is never written while reset is asserted.
    if (rst) begin
      wr    = 1'b0;
      reg_a = '0;
      reg_b = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      level_q <= 5'd1;
      idx_q   <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      wr_q    <= wr;
    end
  end

  assign reg_en = wr;
  assign level  = level_q;
  assign busy   = (state_q == ST_LOAD) || (state_q == ST_SHOW) || (state_q == ST_GAP) ||
                  (state_q == ST_INPUT) || (state_q == ST_CHECK);
  assign win    = (state_q == ST_WIN);
  assign lose   = (state_q == ST_LOSE);

endmodule

// File: doc/memgame_round_ctrl.md
Name: memgame_round_ctrl

Overview:
- Round sequencer for the memory game. Owns the write port of the 64-bit dual register (`en`/`A`/`B` in, `X`/`Y` back).
- `X` holds the target pattern: 16 nibble symbols. `Y` holds the player's entered symbols.
- Each round the FSM loads a fresh pattern, shows the first `level` symbols, collects `level` button entries, compares, and advances or ends the game.
- Sits between the button debouncer and the LED/7-seg display driver.

Parameters:
- SHOW_CYCLES, 50000000: clock cycles each symbol is displayed (benches use 4).
- GAP_CYCLES, 12500000: blank cycles between displayed symbols (benches use 2).
- MAX_LEVEL, 16: final level, range 1..16 (one nibble per level).
- SEED, 64'hACE1_0000_0000_0001: LFSR reset value; must be nonzero.
- TIMEOUT_CYCLES, 500000000: input timeout, used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a game from IDLE/WIN/LOSE
- btn_valid  in  1  one-cycle pulse per debounced press
- btn_code  in  4  symbol pressed, sampled when btn_valid=1
- reg_x  in  64  pattern register contents (`X`)
- reg_y  in  64  entry register contents (`Y`)
- reg_en  out  1  register write enable
- reg_a  out  64  next pattern value
- reg_b  out  64  next entry value
- disp_valid  out  1  display symbol active
- disp_code  out  4  symbol to display
- level  out  5  current level, 1..MAX_LEVEL
- busy  out  1  high in LOAD, SHOW, GAP, INPUT, CHECK
- win  out  1  high in WIN
- lose  out  1  high in LOSE

Behaviour:
- Reset (sync, active-high, clk domain):
  - state=IDLE, level=1, lfsr=SEED, counters=0.
  - All outputs 0, except level=1.
  - Reset mid-round aborts the round. The register is not written during reset.
- LFSR: 64-bit Galois, taps 64,63,61,60. Steps exactly once per LOAD, not free-running, so patterns are deterministic from SEED.
- IDLE: wait for start. start sets level=1 and goes to LOAD.
- LOAD (1 cycle):
  - reg_en=1, reg_a=lfsr_next, reg_b=0.
  - lfsr<=lfsr_next, idx<=level-1.
  - Go to SHOW.
- SHOW:
  - disp_valid=1, disp_code=reg_x[4*idx+:4] for SHOW_CYCLES cycles, then go to GAP.
  - The register is written in LOAD, so reg_x is valid in the first SHOW cycle.
- GAP:
  - disp_valid=0 for GAP_CYCLES cycles.
  - If idx==0 go to INPUT with cnt=0; otherwise idx<=idx-1 and return to SHOW.
- INPUT, on btn_valid:
  - reg_en=1 for 1 cycle, reg_a=reg_x, reg_b={reg_y[59:0],btn_code}, cnt<=cnt+1.
  - When cnt reaches level, go to CHECK.
  - btn_valid is ignored in all other states.
  - Ordering: the first entered symbol lands at nibble level-1, matching display order (nibble level-1 shown first).
- CHECK (1 cycle): compare reg_x[4*level-1:0] with reg_y[4*level-1:0], masked to 4*level bits.
  - Mismatch: go to LOSE.
  - Match and level==MAX_LEVEL: go to WIN.
  - Match otherwise: level<=level+1, go to LOAD.
- WIN / LOSE:
  - Outputs held, level frozen.
  - start restarts at level=1 with the LFSR continuing (no reseed).
- Boundaries:
  - start in a busy state is ignored.
  - btn_valid in the same cycle as the last GAP cycle is ignored.
  - btn_valid and rst together: rst wins.
  - reg_en is high for at most 1 cycle per event; never two consecutive writes.
  - level never exceeds MAX_LEVEL and never wraps.

Optional Feature:
- Macro: MEMGAME_TIMEOUT_EN.
- Defined:
  - INPUT has a counter cleared on entry and on each btn_valid.
  - Reaching TIMEOUT_CYCLES-1 without a press goes to LOSE next cycle.
  - btn_valid in that same cycle takes priority over the timeout.
- Undefined: no counter, INPUT waits indefinitely, TIMEOUT_CYCLES unused.

Decomposition:
- Package memgame_pkg:
  - state encoding (IDLE, LOAD, SHOW, GAP, INPUT, CHECK, WIN, LOSE as 3-bit localparams);
  - the LFSR tap mask constant;
  - SYM_W=4 and PAT_W=64.
- Sub-module memgame_lfsr64: clk, rst, step, q; SEED parameter. Single instance.
- Display timing counters stay inline.

Test Plan:
- Reset then start, with SEED default, SHOW_CYCLES=4, GAP_CYCLES=2:
  - reg_en high exactly 1 cycle; reg_a equals one Galois step of SEED; reg_b=0.
  - disp_valid high for 4 cycles showing reg_x[3:0], then low for 2.
- Level 1: press the displayed symbol -> CHECK match, level=2, second LOAD. Then level 2 shows nibble1 then nibble0.
- Level 3 with a wrong third press (correct^4'h1) -> lose=1 one cycle after CHECK; busy=0; level stays 3.
- Force MAX_LEVEL=2 and enter correct sequences -> win=1 after level-2 CHECK; start returns level to 1.
- rst asserted mid-SHOW and mid-INPUT -> next cycle state IDLE, all outputs 0, level=1, no reg_en pulse. btn_valid during SHOW causes no reg write.
- With MEMGAME_TIMEOUT_EN and TIMEOUT_CYCLES=10: no press -> lose asserts 10 cycles after INPUT entry. A press at cycle 9 resets the count and no loss occurs.
